// File: rtl/sodor_mem_pkg.sv
// Shared types and constants for the Sodor memory arbiter: access-type codes,
// FSM states, port identifiers and the timeout reply word.
package sodor_mem_pkg;

    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESP_LOCAL} state_e;
    typedef enum logic {IMEM, DMEM} port_e;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/sodor_mem_lane_align.sv
// Byte-lane steering for sub-word accesses: store byte enables/replicated data,
// load extraction with sign/zero extension, and the misalignment check.
module sodor_mem_lane_align
    import sodor_mem_pkg::*;
(
    input  logic [2:0]  typ,
    input  logic [1:0]  offset,
    input  logic [31:0] st_in,
    input  logic [31:0] ld_in,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [31:0] shifted;

    always_comb begin
        shifted  = ld_in >> {offset, 3'b000};
        st_be    = 4'hF;
        st_data  = st_in;
        ld_data  = shifted;
        misalign = (offset != 2'b00);
        // Any code outside the byte/half families, including illegal ones, acts as a word.
        case (typ)
            MT_B, MT_BU: begin
                st_be    = 4'b0001 << offset;
                st_data  = {4{st_in[7:0]}};
                ld_data  = (typ == MT_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                         : {24'b0, shifted[7:0]};
                misalign = 1'b0;
            end
            MT_H, MT_HU: begin
                st_be    = 4'b0011 << {offset[1], 1'b0};
                st_data  = {2{st_in[15:0]}};
                ld_data  = (typ == MT_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                         : {16'b0, shifted[15:0]};
                misalign = offset[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sodor_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between Sodor's fetch and
// data ports, one transaction outstanding, with sub-word store/load handling.
module sodor_mem_arbiter
    import sodor_mem_pkg::*;
#(
    parameter int SIZE_OF_THE_BUS = 32,
    parameter int TIMEOUT         = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       imem_req_valid,
    output logic                       imem_req_ready,
    input  logic [SIZE_OF_THE_BUS-1:0] imem_req_addr,
    output logic                       imem_resp_valid,
    output logic [SIZE_OF_THE_BUS-1:0] imem_resp_data,
    input  logic                       dmem_req_valid,
    output logic                       dmem_req_ready,
    input  logic [SIZE_OF_THE_BUS-1:0] dmem_req_addr,
    input  logic [SIZE_OF_THE_BUS-1:0] dmem_req_data,
    input  logic                       dmem_req_write_en,
    input  logic [2:0]                 dmem_req_bits_typ,
    output logic                       dmem_resp_valid,
    output logic [SIZE_OF_THE_BUS-1:0] dmem_resp_data,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [SIZE_OF_THE_BUS-1:0] mem_req_addr,
    output logic [SIZE_OF_THE_BUS-1:0] mem_req_data,
    output logic                       mem_req_we,
    output logic [3:0]                 mem_req_be,
    input  logic                       mem_resp_valid,
    input  logic [SIZE_OF_THE_BUS-1:0] mem_resp_data,
    output logic                       busy,
    output logic                       timeout_err,
    output logic                       misalign_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e                     state_q, state_d;
    port_e                      last_grant_q, last_grant_d, port_q, port_d;
    logic [SIZE_OF_THE_BUS-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]                 be_q, be_d;
    logic                       we_q, we_d;
    logic [2:0]                 typ_q, typ_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       ivld_q, ivld_d, dvld_q, dvld_d;
    logic [SIZE_OF_THE_BUS-1:0] idata_q, idata_d, ddata_q, ddata_d;
    logic                       terr_q, terr_d, merr_q, merr_d;
    logic                       grant_imem, grant_dmem;

    logic [2:0]                 la_typ;
    logic [1:0]                 la_off;
    logic [3:0]                 la_be;
    logic [SIZE_OF_THE_BUS-1:0] la_st_data, la_ld_data;
    logic                       la_misalign;

    // Readies are gated by rst_n so they read 0 while reset is held.
    always_comb begin
        grant_imem = 1'b0;
        grant_dmem = 1'b0;
        if (rst_n && state_q == IDLE) begin
            if (imem_req_valid && dmem_req_valid) begin
                grant_imem = (last_grant_q == DMEM);
                grant_dmem = (last_grant_q == IMEM);
            end else begin
                grant_imem = imem_req_valid;
                grant_dmem = dmem_req_valid;
            end
        end
    end

    // The aligner sees the live request while idle and the latched one afterwards.
    assign la_typ = (state_q == IDLE) ? dmem_req_bits_typ : typ_q;
    assign la_off = (state_q == IDLE) ? dmem_req_addr[1:0] : addr_q[1:0];

    sodor_mem_lane_align u_lane_align (
        .typ      (la_typ),
        .offset   (la_off),
        .st_in    (dmem_req_data),
        .ld_in    (mem_resp_data),
        .st_be    (la_be),
        .st_data  (la_st_data),
        .ld_data  (la_ld_data),
        .misalign (la_misalign)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        we_d         = we_q;
        typ_d        = typ_q;
        cnt_d        = cnt_q;
        ivld_d       = 1'b0;
        dvld_d       = 1'b0;
        idata_d      = idata_q;
        ddata_d      = ddata_q;
        terr_d       = terr_q;
        merr_d       = merr_q;
        case (state_q)
            IDLE: begin
                if (grant_imem) begin
                    port_d       = IMEM;
                    last_grant_d = IMEM;
                    addr_d       = imem_req_addr;
                    wdata_d      = '0;
                    be_d         = 4'hF;
                    we_d         = 1'b0;
                    typ_d        = MT_W;
                    state_d      = ISSUE;
                end else if (grant_dmem) begin
                    port_d       = DMEM;
                    last_grant_d = DMEM;
                    addr_d       = dmem_req_addr;
                    wdata_d      = la_st_data;
                    be_d         = dmem_req_write_en ? la_be : 4'hF;
                    we_d         = dmem_req_write_en;
                    typ_d        = dmem_req_bits_typ;
                    if (la_misalign) begin
                        merr_d  = 1'b1;
                        dvld_d  = 1'b1;
                        ddata_d = '0;
                        state_d = RESP_LOCAL;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                    if (port_q == IMEM) begin
                        ivld_d  = 1'b1;
                        idata_d = mem_resp_data;
                    end else begin
                        dvld_d  = 1'b1;
                        ddata_d = we_q ? '0 : la_ld_data;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                    if (port_q == IMEM) begin
                        ivld_d  = 1'b1;
                        idata_d = TIMEOUT_DATA;
                    end else begin
                        dvld_d  = 1'b1;
                        ddata_d = TIMEOUT_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP_LOCAL: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= DMEM;
            port_q       <= IMEM;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            typ_q        <= '0;
            cnt_q        <= '0;
            ivld_q       <= 1'b0;
            dvld_q       <= 1'b0;
            idata_q      <= '0;
            ddata_q      <= '0;
            terr_q       <= 1'b0;
            merr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            we_q         <= we_d;
            typ_q        <= typ_d;
            cnt_q        <= cnt_d;
            ivld_q       <= ivld_d;
            dvld_q       <= dvld_d;
            idata_q      <= idata_d;
            ddata_q      <= ddata_d;
            terr_q       <= terr_d;
            merr_q       <= merr_d;
        end
    end

    assign imem_req_ready  = grant_imem;
    assign dmem_req_ready  = grant_dmem;
    assign imem_resp_valid = ivld_q;
    assign imem_resp_data  = idata_q;
    assign dmem_resp_valid = dvld_q;
    assign dmem_resp_data  = ddata_q;
    assign mem_req_valid   = (state_q == ISSUE);
    assign mem_req_addr    = {addr_q[SIZE_OF_THE_BUS-1:2], 2'b00};
    assign mem_req_data    = wdata_q;
    assign mem_req_we      = we_q;
    assign mem_req_be      = be_q;
    assign busy            = (state_q != IDLE);
    assign timeout_err     = terr_q;
    assign misalign_err    = merr_q;

endmodule

// File: tb/tb_sodor_mem_arbiter.sv
// Scoreboard bench for sodor_mem_arbiter: expected backend requests and requester
// responses are queued at issue time and popped by independent monitors.
module tb_sodor_mem_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [3:0]  be;
        bit          chk_data;
    } req_t;

    typedef struct {
        logic [31:0] data;
        bit          chk;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dmem_req_valid, dmem_req_ready;
    logic [31:0] dmem_req_addr, dmem_req_data;
    logic        dmem_req_write_en;
    logic [2:0]  dmem_req_bits_typ;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr, mem_req_data;
    logic        mem_req_we;
    logic [3:0]  mem_req_be;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        busy, timeout_err, misalign_err;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   imem_resp_cyc = 0;
    int   dmem_resp_cyc = 0;
    int   hs_cyc = 0;
    int   resp_cnt = 0;
    int   late_req_n = 0;
    int   late_done = 0;
    bit   be_mute = 0;
    logic [31:0] be_rdata = 32'h0;

    req_t exp_req[$];
    rsp_t exp_imem[$];
    rsp_t exp_dmem[$];

    sodor_mem_arbiter #(.SIZE_OF_THE_BUS(32), .TIMEOUT(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .dmem_req_valid    (dmem_req_valid),
        .dmem_req_ready    (dmem_req_ready),
        .dmem_req_addr     (dmem_req_addr),
        .dmem_req_data     (dmem_req_data),
        .dmem_req_write_en (dmem_req_write_en),
        .dmem_req_bits_typ (dmem_req_bits_typ),
        .dmem_resp_valid   (dmem_resp_valid),
        .dmem_resp_data    (dmem_resp_data),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_addr      (mem_req_addr),
        .mem_req_data      (mem_req_data),
        .mem_req_we        (mem_req_we),
        .mem_req_be        (mem_req_be),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_data     (mem_resp_data),
        .busy              (busy),
        .timeout_err       (timeout_err),
        .misalign_err      (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_req(input logic [31:0] a, input logic [31:0] d, input logic we,
                                     input logic [3:0] be, input bit cd);
        req_t r;
        r.addr = a; r.data = d; r.we = we; r.be = be; r.chk_data = cd;
        exp_req.push_back(r);
    endfunction

    function automatic void push_rsp(input bit is_d, input logic [31:0] d, input bit c);
        rsp_t r;
        r.data = d; r.chk = c;
        if (is_d) exp_dmem.push_back(r);
        else      exp_imem.push_back(r);
    endfunction

    // Backend model: checks each accepted request, answers one cycle later unless muted.
    always begin : backend
        req_t r;
        @(negedge clk);
        if (late_done != late_req_n) begin
            late_done++;
            @(posedge clk); #1;
            mem_resp_data  = 32'h0BAD_0BAD;
            mem_resp_valid = 1'b1;
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
        end else if (mem_req_valid && mem_req_ready) begin
            hs_cyc = cyc;
            if (exp_req.size() == 0) begin
                chk("unexpected_mem_req", 32'(mem_req_valid), 32'd0);
            end else begin
                r = exp_req.pop_front();
                chk("mem_req_addr", mem_req_addr, r.addr);
                chk("mem_req_be", 32'(mem_req_be), 32'(r.be));
                chk("mem_req_we", 32'(mem_req_we), 32'(r.we));
                if (r.chk_data) chk("mem_req_data", mem_req_data, r.data);
            end
            if (!be_mute) begin
                @(posedge clk); #1;
                mem_resp_data  = be_rdata;
                mem_resp_valid = 1'b1;
                @(posedge clk); #1;
                mem_resp_valid = 1'b0;
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin : resp_mon
        rsp_t r;
        if (imem_resp_valid) begin
            resp_cnt++;
            imem_resp_cyc = cyc;
            if (exp_imem.size() == 0) begin
                chk("unexpected_imem_resp", 32'(imem_resp_valid), 32'd0);
            end else begin
                r = exp_imem.pop_front();
                if (r.chk) chk("imem_resp_data", imem_resp_data, r.data);
            end
        end
        if (dmem_resp_valid) begin
            resp_cnt++;
            dmem_resp_cyc = cyc;
            if (exp_dmem.size() == 0) begin
                chk("unexpected_dmem_resp", 32'(dmem_resp_valid), 32'd0);
            end else begin
                r = exp_dmem.pop_front();
                if (r.chk) chk("dmem_resp_data", dmem_resp_data, r.data);
            end
        end
    end

    task automatic do_req(input bit is_d, input logic [31:0] addr, input logic [31:0] wd,
                          input logic we, input logic [2:0] typ, output int acc);
        bit ok;
        ok  = 0;
        acc = 0;
        @(posedge clk); #1;
        if (is_d) begin
            dmem_req_addr     = addr;
            dmem_req_data     = wd;
            dmem_req_write_en = we;
            dmem_req_bits_typ = typ;
            dmem_req_valid    = 1'b1;
        end else begin
            imem_req_addr  = addr;
            imem_req_valid = 1'b1;
        end
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (is_d ? dmem_req_ready : imem_req_ready) begin
                ok  = 1;
                acc = cyc;
            end
        end
        chk("accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); #1;
            if (!busy && exp_imem.size() == 0 && exp_dmem.size() == 0 && exp_req.size() == 0)
                ok = 1;
        end
        chk("quiet", 32'(ok), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        logic [8:0] ctl;
        ctl = {imem_req_ready, dmem_req_ready, imem_resp_valid, dmem_resp_valid,
               mem_req_valid, mem_req_we, busy, timeout_err, misalign_err};
        chk({tag, "_ctrl"}, 32'(ctl), 32'd0);
        chk({tag, "_addr_be"}, mem_req_addr | 32'(mem_req_be), 32'd0);
        chk({tag, "_data"}, mem_req_data | imem_resp_data | dmem_resp_data, 32'd0);
    endtask

    // Both ports held valid: grants must alternate starting with IMEM.
    task automatic tie_run(input int n);
        int got;
        got = 0;
        be_rdata = 32'h0000_0013;
        for (int k = 0; k < n; k++) begin
            if (k % 2 == 0) begin
                push_req(32'h100, 32'h0, 1'b0, 4'hF, 0);
                push_rsp(0, 32'h0000_0013, 1);
            end else begin
                push_req(32'h40, 32'h0, 1'b0, 4'hF, 0);
                push_rsp(1, 32'h0000_0013, 1);
            end
        end
        imem_req_addr     = 32'h100;
        dmem_req_addr     = 32'h40;
        dmem_req_data     = 32'h0;
        dmem_req_write_en = 1'b0;
        dmem_req_bits_typ = 3'd3;
        imem_req_valid    = 1'b1;
        dmem_req_valid    = 1'b1;
        for (int i = 0; i < 200 && got < n; i++) begin
            @(negedge clk);
            if (imem_req_ready || dmem_req_ready) begin
                chk("tie_grant", 32'({imem_req_ready, dmem_req_ready}),
                    (got % 2 == 0) ? 32'd2 : 32'd1);
                got++;
            end
        end
        chk("tie_count", got, n);
        @(posedge clk); #1;
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin : stim
        int acc;
        int c0;
        rst_n             = 1'b0;
        imem_req_valid    = 1'b1;
        imem_req_addr     = 32'h100;
        dmem_req_valid    = 1'b1;
        dmem_req_addr     = 32'h40;
        dmem_req_data     = 32'h0;
        dmem_req_write_en = 1'b0;
        dmem_req_bits_typ = 3'd3;
        mem_req_ready     = 1'b1;
        mem_resp_valid    = 1'b0;
        mem_resp_data     = 32'h0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        tie_run(4);
        wait_quiet();

        // Fetch latency
        be_rdata = 32'h0000_0013;
        push_req(32'h100, 32'h0, 1'b0, 4'hF, 0);
        push_rsp(0, 32'h0000_0013, 1);
        do_req(0, 32'h100, 32'h0, 1'b0, 3'd3, acc);
        wait_quiet();
        chk("imem_latency", imem_resp_cyc - acc, 3);

        // Stores
        push_req(32'h200, 32'hABAB_ABAB, 1'b1, 4'b1000, 1);
        push_rsp(1, 32'h0, 0);
        do_req(1, 32'h203, 32'h0000_00AB, 1'b1, 3'd1, acc);
        wait_quiet();
        push_req(32'h200, 32'h1234_1234, 1'b1, 4'b1100, 1);
        push_rsp(1, 32'h0, 0);
        do_req(1, 32'h202, 32'h0000_1234, 1'b1, 3'd2, acc);
        wait_quiet();
        push_req(32'h10, 32'hCAFE_F00D, 1'b1, 4'hF, 1);
        push_rsp(1, 32'h0, 0);
        do_req(1, 32'h10, 32'hCAFE_F00D, 1'b1, 3'd0, acc);
        wait_quiet();

        // Loads with extension
        be_rdata = 32'h8012_3456;
        push_req(32'h200, 32'h0, 1'b0, 4'hF, 0);
        push_rsp(1, 32'hFFFF_FF80, 1);
        do_req(1, 32'h203, 32'h0, 1'b0, 3'd1, acc);
        wait_quiet();
        push_req(32'h200, 32'h0, 1'b0, 4'hF, 0);
        push_rsp(1, 32'h0000_0080, 1);
        do_req(1, 32'h203, 32'h0, 1'b0, 3'd5, acc);
        wait_quiet();
        push_req(32'h200, 32'h0, 1'b0, 4'hF, 0);
        push_rsp(1, 32'hFFFF_8012, 1);
        do_req(1, 32'h202, 32'h0, 1'b0, 3'd2, acc);
        wait_quiet();
        push_req(32'h0, 32'h0, 1'b0, 4'hF, 0);
        push_rsp(1, 32'h0000_8012, 1);
        do_req(1, 32'h002, 32'h0, 1'b0, 3'd6, acc);
        wait_quiet();
        push_req(32'h200, 32'h0, 1'b0, 4'hF, 0);
        push_rsp(1, 32'h0000_0034, 1);
        do_req(1, 32'h201, 32'h0, 1'b0, 3'd1, acc);
        wait_quiet();

        // Misaligned accesses never reach the backend
        chk("misalign_err_before", 32'(misalign_err), 32'd0);
        push_rsp(1, 32'h0, 1);
        do_req(1, 32'h101, 32'h0, 1'b0, 3'd2, acc);
        wait_quiet();
        chk("misalign_latency", dmem_resp_cyc - acc, 1);
        chk("misalign_err", 32'(misalign_err), 32'd1);
        push_rsp(1, 32'h0, 1);
        do_req(1, 32'h102, 32'h0, 1'b0, 3'd3, acc);
        wait_quiet();

        // Timeout, then a late backend response that must be dropped
        chk("timeout_err_before", 32'(timeout_err), 32'd0);
        be_mute = 1;
        push_req(32'h300, 32'h0, 1'b0, 4'hF, 0);
        push_rsp(0, 32'hDEAD_BEEF, 1);
        do_req(0, 32'h300, 32'h0, 1'b0, 3'd3, acc);
        wait_quiet();
        chk("timeout_latency", imem_resp_cyc - hs_cyc, 9);
        chk("timeout_err", 32'(timeout_err), 32'd1);
        be_mute = 0;
        c0 = resp_cnt;
        late_req_n++;
        repeat (6) @(negedge clk);
        chk("late_resp_dropped", resp_cnt - c0, 0);
        chk("late_resp_idle", 32'(busy), 32'd0);

        // Reset while waiting for the backend
        be_mute = 1;
        push_req(32'h400, 32'h0, 1'b0, 4'hF, 0);
        do_req(0, 32'h400, 32'h0, 1'b0, 3'd3, acc);
        repeat (2) @(negedge clk);
        chk("busy_before_reset", 32'(busy), 32'd1);
        imem_req_valid = 1'b1;
        dmem_req_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        be_mute = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tie_run(1);
        wait_quiet();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
